video_mode_sequencer: RTL and testbench

- Owns the live configuration of the video mixer: scandoubler enable, scanline level, hq2x and mono.
- A requester (OSD/status logic) posts a new configuration through a req/ack handshake.
- The block holds the request until a frame boundary, defined as the rising edge of the core VSync, and applies it there.
- Changes that alter output timing (scandoubler or hq2x) also assert a mute for a programmable number of frames, so the mixer output is blanked while the scaler resettles.

---
 rtl/video_mode_sequencer.sv | 136 +++++++++++++
 tb/tb_video_mode_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mode_sequencer.sv
// Holds the live video mixer mode. A requested mode is latched via req/ack and applied on
// the next VSync rising edge (or after a timeout). Output-timing changes also mute the mixer.
module video_mode_sequencer #(
    parameter int          MUTE_FRAMES = 2,
    parameter logic [23:0] TIMEOUT     = 24'd4_000_000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       cfg_req,
    output logic       cfg_ack,
    input  logic       cfg_scandoubler,
    input  logic [1:0] cfg_scanlines,
    input  logic       cfg_hq2x,
    input  logic       cfg_mono,
    input  logic       VSync,
    output logic       scandoubler,
    output logic [1:0] scanlines,
    output logic       hq2x,
    output logic       mono,
    output logic       mute,
    output logic       busy
);
    localparam int              FC_W      = (MUTE_FRAMES > 0) ? $clog2(MUTE_FRAMES + 1) : 1;
    localparam logic [FC_W-1:0] FRAME_END = FC_W'(MUTE_FRAMES);
    localparam logic [23:0]     TO_LAST   = TIMEOUT - 24'd1;

    typedef enum logic [1:0] {IDLE, WAIT_VS, MUTE} state_t;

    // Config word layout: {scandoubler, scanlines[1:0], hq2x, mono}
    state_t          state_reg, state_next;
    logic [4:0]      applied_reg, applied_next;
    logic [4:0]      pending_reg, pending_next;
    logic [23:0]     to_cnt_reg, to_cnt_next;
    logic [FC_W-1:0] fr_cnt_reg, fr_cnt_next;
    logic            mute_reg, mute_next;
    logic            ack_reg, ack_next;
    logic            armed_reg, armed_next;
    logic            busy_reg;
    logic            old_vs_reg;
    logic            vs_rise;
    logic            timing_change;
    logic [4:0]      cfg_word;
    logic [FC_W-1:0] fr_cnt_inc;

    assign cfg_word      = {cfg_scandoubler, cfg_scanlines, cfg_hq2x, cfg_mono};
    assign vs_rise       = VSync & ~old_vs_reg;
    assign fr_cnt_inc    = fr_cnt_reg + FC_W'(1);
    assign timing_change = (pending_reg[4] != applied_reg[4]) || (pending_reg[1] != applied_reg[1]);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            applied_reg <= '0;
            pending_reg <= '0;
            to_cnt_reg  <= '0;
            fr_cnt_reg  <= '0;
            mute_reg    <= 1'b0;
            ack_reg     <= 1'b0;
            armed_reg   <= 1'b1;
            busy_reg    <= 1'b0;
            old_vs_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            applied_reg <= applied_next;
            pending_reg <= pending_next;
            to_cnt_reg  <= to_cnt_next;
            fr_cnt_reg  <= fr_cnt_next;
            mute_reg    <= mute_next;
            ack_reg     <= ack_next;
            armed_reg   <= armed_next;
            busy_reg    <= (state_next != IDLE);
            old_vs_reg  <= VSync;
        end
    end

    always_comb begin
        state_next   = state_reg;
        applied_next = applied_reg;
        pending_next = pending_reg;
        to_cnt_next  = to_cnt_reg;
        fr_cnt_next  = fr_cnt_reg;
        mute_next    = mute_reg;
        ack_next     = 1'b0;
        armed_next   = armed_reg;
        // A held request must be seen low once before another one can be accepted
        if (!cfg_req) begin
            armed_next = 1'b1;
        end
        case (state_reg)
            IDLE: begin
                if (cfg_req && armed_reg) begin
                    ack_next     = 1'b1;
                    armed_next   = 1'b0;
                    pending_next = cfg_word;
                    if (cfg_word != applied_reg) begin
                        state_next  = WAIT_VS;
                        to_cnt_next = '0;
                    end
                end
            end
            WAIT_VS: begin
                to_cnt_next = to_cnt_reg + 24'd1;
                if (vs_rise || (to_cnt_reg == TO_LAST)) begin
                    applied_next = pending_reg;
                    if ((MUTE_FRAMES > 0) && timing_change) begin
                        mute_next   = 1'b1;
                        fr_cnt_next = '0;
                        state_next  = MUTE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            MUTE: begin
                // No timeout here: the scaler is only trusted again after real frames
                if (vs_rise) begin
                    fr_cnt_next = fr_cnt_inc;
                    if (fr_cnt_inc == FRAME_END) begin
                        mute_next  = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign scandoubler = applied_reg[4];
    assign scanlines   = applied_reg[3:2];
    assign hq2x        = applied_reg[1];
    assign mono        = applied_reg[0];
    assign mute        = mute_reg;
    assign cfg_ack     = ack_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Randomized bench for video_mode_sequencer against an event-level reference model
// (pending request, cycles waited, frames of mute left).
module tb_video_mode_sequencer;
    localparam int MF = 2;
    localparam int TO = 100;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       cfg_req = 1'b0;
    logic       cfg_ack;
    logic       cfg_scandoubler = 1'b0;
    logic [1:0] cfg_scanlines = 2'b00;
    logic       cfg_hq2x = 1'b0;
    logic       cfg_mono = 1'b0;
    logic       VSync = 1'b0;
    logic       scandoubler;
    logic [1:0] scanlines;
    logic       hq2x;
    logic       mono;
    logic       mute;
    logic       busy;

    always #5 clk_sys = ~clk_sys;

    video_mode_sequencer #(
        .MUTE_FRAMES (MF),
        .TIMEOUT     (24'(TO))
    ) dut (
        .clk_sys         (clk_sys),
        .reset_n         (reset_n),
        .cfg_req         (cfg_req),
        .cfg_ack         (cfg_ack),
        .cfg_scandoubler (cfg_scandoubler),
        .cfg_scanlines   (cfg_scanlines),
        .cfg_hq2x        (cfg_hq2x),
        .cfg_mono        (cfg_mono),
        .VSync           (VSync),
        .scandoubler     (scandoubler),
        .scanlines       (scanlines),
        .hq2x            (hq2x),
        .mono            (mono),
        .mute            (mute),
        .busy            (busy)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the mode on screen, a pending mode waiting for a frame start,
    // how long it has waited, and how many frame starts remain muted.
    logic [4:0] m_applied;
    logic [4:0] m_pending;
    bit         m_waiting;
    int         m_wait_cnt;
    int         m_frames_left;
    bit         m_mute;
    bit         m_ack;
    bit         m_armed;
    bit         m_vs_prev;
    int         n_timeout = 0;
    int         n_acks = 0;

    // Stimulus state
    int vs_cnt = 0;
    int vs_period = 1000;
    int vs_fixed = 1000;
    int req_hold = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return m_waiting || (m_frames_left > 0);
    endfunction

    task model_reset();
        m_applied     = '0;
        m_pending     = '0;
        m_waiting     = 1'b0;
        m_wait_cnt    = 0;
        m_frames_left = 0;
        m_mute        = 1'b0;
        m_ack         = 1'b0;
        m_armed       = 1'b1;
        m_vs_prev     = 1'b0;
    endtask

    task model_step();
        bit         frame_start;
        bit         retimes;
        logic [4:0] want;
        frame_start = VSync && !m_vs_prev;
        want = {cfg_scandoubler, cfg_scanlines, cfg_hq2x, cfg_mono};
        m_ack = 1'b0;
        if (m_waiting) begin
            m_wait_cnt++;
            if (frame_start || m_wait_cnt == TO) begin
                if (!frame_start) n_timeout++;
                retimes = (m_pending[4] != m_applied[4]) || (m_pending[1] != m_applied[1]);
                m_applied = m_pending;
                m_waiting = 1'b0;
                if (retimes && MF > 0) begin
                    m_frames_left = MF;
                    m_mute = 1'b1;
                end
            end
        end else if (m_frames_left > 0) begin
            if (frame_start) begin
                m_frames_left--;
                if (m_frames_left == 0) m_mute = 1'b0;
            end
        end else if (cfg_req && m_armed) begin
            m_ack = 1'b1;
            m_armed = 1'b0;
            n_acks++;
            $display("[%0t] request accepted: cfg=%b on_screen=%b", $time, want, m_applied);
            if (want != m_applied) begin
                m_pending = want;
                m_waiting = 1'b1;
                m_wait_cnt = 0;
            end
        end
        if (!cfg_req) m_armed = 1'b1;
        m_vs_prev = VSync;
    endtask

    task compare_all();
        check("applied", {27'd0, scandoubler, scanlines, hq2x, mono}, {27'd0, m_applied});
        check("mute", {31'd0, mute}, {31'd0, m_mute});
        check("cfg_ack", {31'd0, cfg_ack}, {31'd0, m_ack});
        check("busy", {31'd0, busy}, {31'd0, m_busy()});
    endtask

    task pick_cfg(input int mode);
        logic [4:0] c;
        int         sel;
        c = m_applied;
        sel = (mode == 1) ? 4 : (mode == 2) ? 5 : int'($urandom_range(0, 3));
        case (sel)
            1: c[3:2] = 2'($urandom_range(0, 3));
            2: c[0] = ~c[0];
            3: c = 5'($urandom);
            4: c[1] = ~c[1];
            5: c[4] = ~c[4];
            default: ;
        endcase
        {cfg_scandoubler, cfg_scanlines, cfg_hq2x, cfg_mono} = c;
    endtask

    // One clock: drive inputs on the falling edge, step the model on the rising edge,
    // compare just after it.
    task cycle(input bit vs_en, input int req_pct, input int mode);
        @(negedge clk_sys);
        if (vs_en) begin
            vs_cnt++;
            if (vs_cnt >= vs_period) begin
                vs_cnt = 0;
                vs_period = (vs_fixed > 0) ? vs_fixed : int'($urandom_range(40, 160));
            end
            VSync = (vs_cnt < 3);
        end else begin
            VSync = 1'b0;
        end
        if (req_hold > 0) begin
            req_hold--;
            if (req_hold == 0) cfg_req = 1'b0;
        end else if (cfg_req && cfg_ack) begin
            if ($urandom_range(0, 3) == 0) req_hold = 20;
            else cfg_req = 1'b0;
        end else if (!cfg_req && int'($urandom_range(0, 99)) < req_pct) begin
            cfg_req = 1'b1;
            pick_cfg(mode);
        end
        @(posedge clk_sys);
        if (!reset_n) model_reset();
        else model_step();
        #1 compare_all();
    endtask

    initial begin
        int to_before;
        int acks_before;
        int guard;
        model_reset();
        repeat (3) cycle(1'b0, 0, 0);
        reset_n = 1'b1;

        // Quiet frames after reset, 1000-clock VSync period
        vs_fixed = 1000;
        vs_period = 1000;
        repeat (5000) cycle(1'b1, 0, 0);

        // Mixed random traffic with jittered frame lengths (some exceed the timeout)
        vs_fixed = 0;
        repeat (6000) cycle(1'b1, 5, 0);

        // Drain to idle, then stall VSync and request hq2x toggles
        guard = 0;
        while ((m_busy() || cfg_req) && guard < 4000) begin
            cycle(1'b1, 0, 0);
            guard++;
        end
        check("drain_before_stall", {31'd0, m_busy()}, 32'd0);
        to_before = n_timeout;
        repeat (1500) cycle(1'b0, 20, 1);
        check("timeout_apply_seen", {31'd0, n_timeout > to_before}, 32'd1);
        check("mute_held_no_vsync", {31'd0, mute}, 32'd1);

        // VSync resumes and releases the mute
        vs_cnt = 0;
        repeat (600) cycle(1'b1, 5, 0);

        // Reach a muted state via scandoubler toggles, then reset asynchronously
        guard = 0;
        while (!m_mute && guard < 5000) begin
            cycle(1'b1, 10, 2);
            guard++;
        end
        check("reach_mute", {31'd0, m_mute}, 32'd1);
        #2;
        reset_n = 1'b0;
        cfg_req = 1'b0;
        req_hold = 0;
        #1;
        model_reset();
        compare_all();
        check("async_rst_mute", {31'd0, mute}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) cycle(1'b1, 0, 0);
        reset_n = 1'b1;
        acks_before = n_acks;
        repeat (1500) cycle(1'b1, 10, 0);
        check("ack_after_reset", {31'd0, n_acks > acks_before}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
